// File: rtl/regfile_mp_tagged.sv
// regfile_mp_tagged: multi-ported architectural register file with per-register
// rename status (busy bit + producer tag). NUM_RD combinational read ports,
// NUM_WR commit write ports (higher port index = younger op), one rename alloc
// port and a flush that clears every busy bit.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle commit data
// (and its busy clear) onto the read ports.
module regfile_mp_tagged #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  NUM_RD = 4,
    parameter int  NUM_WR = 2,
    parameter int  TAG_W  = 4,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_flush,
    input  logic                    i_alloc_v,
    input  logic [AW-1:0]           i_alloc_rd,
    input  logic [TAG_W-1:0]        i_alloc_tag,
    input  logic [NUM_WR-1:0]       i_wr_v,
    input  logic [NUM_WR*AW-1:0]    i_wr_rd,
    input  logic [NUM_WR*XLEN-1:0]  i_wr_data,
    input  logic [NUM_WR*TAG_W-1:0] i_wr_tag,
    input  logic [NUM_RD*AW-1:0]    i_rd_addr,
    output logic [NUM_RD*XLEN-1:0]  o_rd_data,
    output logic [NUM_RD-1:0]       o_rd_busy,
    output logic [NUM_RD*TAG_W-1:0] o_rd_tag
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [TAG_W-1:0] tag_q [NREGS];
    logic [TAG_W-1:0] tag_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] commit_clr;

    // Commit decode: data next-state and which registers see their producer retire.
    // The youngest port hitting a register decides both the data and the tag match.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r]      = mem_q[r];
            commit_clr[r] = 1'b0;
        end
        mem_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_wr_v[p] && (i_wr_rd[p*AW +: AW] == AW'(r))) begin
                    mem_d[r]      = i_wr_data[p*XLEN +: XLEN];
                    commit_clr[r] = busy_q[r] && (tag_q[r] == i_wr_tag[p*TAG_W +: TAG_W]);
                end
            end
        end
    end

    // Rename status next-state: flush > alloc > commit clear > hold.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            tag_d[r] = tag_q[r];
        end
        if (i_flush) begin
            // Tags are deliberately kept; only the busy bits are dropped.
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~commit_clr;
            if (i_alloc_v && (i_alloc_rd != '0)) begin
                busy_d[i_alloc_rd] = 1'b1;
                tag_d[i_alloc_rd]  = i_alloc_tag;
            end
        end
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // State registers; asynchronous reset wipes data, busy and tags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
                tag_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
                tag_q[r] <= tag_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read ports; x0 is hardwired to zero / not busy.
    always_comb begin
        logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
        logic          byp_clr;
`endif
        o_rd_data = '0;
        o_rd_busy = '0;
        o_rd_tag  = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            ra = i_rd_addr[q*AW +: AW];
            o_rd_data[q*XLEN +: XLEN]   = mem_q[ra];
            o_rd_busy[q]                = busy_q[ra];
            o_rd_tag[q*TAG_W +: TAG_W]  = tag_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Forward the youngest matching commit; alloc status is never forwarded.
            byp_clr = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_wr_v[p] && (i_wr_rd[p*AW +: AW] == ra)) begin
                    o_rd_data[q*XLEN +: XLEN] = i_wr_data[p*XLEN +: XLEN];
                    byp_clr = busy_q[ra] && (tag_q[ra] == i_wr_tag[p*TAG_W +: TAG_W]);
                end
            end
            if (byp_clr && !(i_alloc_v && (i_alloc_rd == ra))) begin
                o_rd_busy[q] = 1'b0;
            end
`endif
            if (ra == '0) begin
                o_rd_data[q*XLEN +: XLEN]  = '0;
                o_rd_busy[q]               = 1'b0;
                o_rd_tag[q*TAG_W +: TAG_W] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_tagged.sv
// Bench for regfile_mp_tagged: directed scenarios plus randomized traffic,
// checked against an array-based reference model of the register file.
module tb_regfile_mp_tagged;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int TAG_W  = 4;
    localparam int AW     = 5;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    i_flush;
    logic                    i_alloc_v;
    logic [AW-1:0]           i_alloc_rd;
    logic [TAG_W-1:0]        i_alloc_tag;
    logic [NUM_WR-1:0]       i_wr_v;
    logic [NUM_WR*AW-1:0]    i_wr_rd;
    logic [NUM_WR*XLEN-1:0]  i_wr_data;
    logic [NUM_WR*TAG_W-1:0] i_wr_tag;
    logic [NUM_RD*AW-1:0]    i_rd_addr;
    logic [NUM_RD*XLEN-1:0]  o_rd_data;
    logic [NUM_RD-1:0]       o_rd_busy;
    logic [NUM_RD*TAG_W-1:0] o_rd_tag;

    regfile_mp_tagged #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rstn(rstn), .i_flush(i_flush),
        .i_alloc_v(i_alloc_v), .i_alloc_rd(i_alloc_rd), .i_alloc_tag(i_alloc_tag),
        .i_wr_v(i_wr_v), .i_wr_rd(i_wr_rd), .i_wr_data(i_wr_data), .i_wr_tag(i_wr_tag),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_busy(o_rd_busy), .o_rd_tag(o_rd_tag)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of each register.
    logic [XLEN-1:0]  mm [NREGS];
    logic             mb [NREGS];
    logic [TAG_W-1:0] mt [NREGS];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mm[r] = '0; mb[r] = 1'b0; mt[r] = '0;
        end
    endtask

    // Apply one clock edge's worth of architectural effects to the model.
    task automatic model_edge();
        int            win [NREGS];
        logic          clr [NREGS];
        logic [AW-1:0] rd;
        for (int r = 0; r < NREGS; r++) win[r] = -1;
        for (int p = 0; p < NUM_WR; p++) begin
            rd = i_wr_rd[p*AW +: AW];
            if (i_wr_v[p] && rd != 0) begin
                mm[rd]  = i_wr_data[p*XLEN +: XLEN];
                win[rd] = p;
            end
        end
        for (int r = 0; r < NREGS; r++)
            clr[r] = (win[r] >= 0) && mb[r] && (mt[r] == i_wr_tag[win[r]*TAG_W +: TAG_W]);
        if (i_flush) begin
            for (int r = 0; r < NREGS; r++) mb[r] = 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) if (clr[r]) mb[r] = 1'b0;
            if (i_alloc_v && i_alloc_rd != 0) begin
                mb[i_alloc_rd] = 1'b1;
                mt[i_alloc_rd] = i_alloc_tag;
            end
        end
    endtask

    // What a read of address a must return given model state and current inputs.
    task automatic model_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                              output logic b, output logic [TAG_W-1:0] t);
        logic clr;
        d = '0; b = 1'b0; t = '0; clr = 1'b0;
        if (a != 0) begin
            d = mm[a]; b = mb[a]; t = mt[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_wr_v[p] && i_wr_rd[p*AW +: AW] == a) begin
                    d   = i_wr_data[p*XLEN +: XLEN];
                    clr = mb[a] && (mt[a] == i_wr_tag[p*TAG_W +: TAG_W]);
                end
            end
            if (clr && !(i_alloc_v && i_alloc_rd == a)) b = 1'b0;
`endif
        end
    endtask

    task automatic idle();
        i_flush = 0; i_alloc_v = 0; i_alloc_rd = '0; i_alloc_tag = '0;
        i_wr_v = '0; i_wr_rd = '0; i_wr_data = '0; i_wr_tag = '0; i_rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                          input logic [TAG_W-1:0] t);
        i_wr_v[p] = 1'b1;
        i_wr_rd[p*AW +: AW] = rd;
        i_wr_data[p*XLEN +: XLEN] = d;
        i_wr_tag[p*TAG_W +: TAG_W] = t;
    endtask

    task automatic set_alloc(input logic [AW-1:0] rd, input logic [TAG_W-1:0] t);
        i_alloc_v = 1'b1; i_alloc_rd = rd; i_alloc_tag = t;
    endtask

    // Read port q against the reference model; tag only meaningful when busy.
    task automatic read_check(input int q, input logic [AW-1:0] a, input string nm);
        logic [XLEN-1:0] d; logic b; logic [TAG_W-1:0] t;
        i_rd_addr[q*AW +: AW] = a;
        #1;
        model_read(a, d, b, t);
        check_val({nm, ".data"}, o_rd_data[q*XLEN +: XLEN], d);
        check_val({nm, ".busy"}, 32'(o_rd_busy[q]), 32'(b));
        if (b || a == 0) check_val({nm, ".tag"}, 32'(o_rd_tag[q*TAG_W +: TAG_W]), 32'(t));
    endtask

    // Read port q against literal expectations.
    task automatic expect_reg(input int q, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                              input logic b, input logic [TAG_W-1:0] t, input bit chk_tag,
                              input string nm);
        i_rd_addr[q*AW +: AW] = a;
        #1;
        check_val({nm, ".data"}, o_rd_data[q*XLEN +: XLEN], d);
        check_val({nm, ".busy"}, 32'(o_rd_busy[q]), 32'(b));
        if (chk_tag) check_val({nm, ".tag"}, 32'(o_rd_tag[q*TAG_W +: TAG_W]), 32'(t));
    endtask

    initial begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] exp_old;
        rstn = 1'b0;
        idle();
        model_reset();
        #2;
        expect_reg(0, 5'd5, 32'h0, 1'b0, 4'h0, 1'b1, "por");
        @(negedge clk);
        rstn = 1'b1;

        // Reset clears state asynchronously and aborts an in-flight write.
        set_wr(0, 5'd5, 32'hDEAD, 4'h0);
        set_alloc(5'd6, 4'h9);
        step();
        expect_reg(0, 5'd5, 32'hDEAD, 1'b0, 4'h0, 1'b0, "pre_rst_x5");
        expect_reg(1, 5'd6, 32'h0, 1'b1, 4'h9, 1'b1, "pre_rst_x6");
        set_wr(1, 5'd5, 32'hBEEF, 4'h0);
        set_alloc(5'd6, 4'h3);
        #1;
        rstn = 1'b0;
        model_reset();
        for (int q = 0; q < NUM_RD; q++)
            expect_reg(q, (q % 2 == 0) ? 5'd5 : 5'd6, 32'h0, 1'b0, 4'h0, 1'b1, $sformatf("rst_async%0d", q));
        @(posedge clk);
        #1;
        expect_reg(0, 5'd5, 32'h0, 1'b0, 4'h0, 1'b1, "rst_abort_x5");
        expect_reg(1, 5'd6, 32'h0, 1'b0, 4'h0, 1'b1, "rst_abort_x6");
        idle();
        @(negedge clk);
        rstn = 1'b1;

        // x0 ignores writes and allocs.
        for (int p = 0; p < NUM_WR; p++) set_wr(p, 5'd0, 32'h1234, 4'h0);
        set_alloc(5'd0, 4'h7);
        read_check(2, 5'd0, "x0_same");
        step();
        expect_reg(0, 5'd0, 32'h0, 1'b0, 4'h0, 1'b1, "x0");

        // Same-register write conflict: youngest port wins.
        set_wr(0, 5'd3, 32'h11, 4'h0);
        set_wr(1, 5'd3, 32'h22, 4'h0);
        step();
        expect_reg(3, 5'd3, 32'h22, 1'b0, 4'h0, 1'b0, "conflict_x3");

        // Tag match / mismatch on commit.
        set_alloc(5'd7, 4'd3); step();
        set_alloc(5'd7, 4'd5); step();
        set_wr(0, 5'd7, 32'hA, 4'd3); step();
        expect_reg(1, 5'd7, 32'hA, 1'b1, 4'd5, 1'b1, "tag_mismatch");
        set_wr(1, 5'd7, 32'hB, 4'd5); step();
        expect_reg(1, 5'd7, 32'hB, 1'b0, 4'd0, 1'b0, "tag_match");

        // Alloc beats a same-cycle busy-clearing commit.
        set_alloc(5'd9, 4'd2); step();
        set_wr(1, 5'd9, 32'h7, 4'd2);
        set_alloc(5'd9, 4'd6);
        step();
        expect_reg(2, 5'd9, 32'h7, 1'b1, 4'd6, 1'b1, "alloc_vs_commit");

        // Flush clears busy and drops a same-cycle alloc.
        set_alloc(5'd4, 4'd1); step();
        set_alloc(5'd8, 4'd2); step();
        set_alloc(5'd10, 4'd3);
        i_flush = 1'b1;
        step();
        expect_reg(0, 5'd4, 32'h0, 1'b0, 4'd0, 1'b0, "flush_x4");
        expect_reg(1, 5'd8, 32'h0, 1'b0, 4'd0, 1'b0, "flush_x8");
        expect_reg(2, 5'd10, 32'h0, 1'b0, 4'd0, 1'b0, "flush_x10");

        // Same-cycle read of a register being written.
        set_wr(0, 5'd12, 32'h33, 4'd0); step();
        set_wr(0, 5'd12, 32'h55, 4'd0);
`ifdef REGFILE_BYPASS_EN
        exp_old = 32'h55;
`else
        exp_old = 32'h33;
`endif
        expect_reg(0, 5'd12, exp_old, 1'b0, 4'd0, 1'b0, "bypass_x12");
        step();
        expect_reg(0, 5'd12, 32'h55, 1'b0, 4'd0, 1'b0, "after_x12");
        set_alloc(5'd13, 4'd4); step();
        set_wr(1, 5'd13, 32'h66, 4'd4);
        read_check(3, 5'd13, "bypass_busy_x13");
        step();
        expect_reg(3, 5'd13, 32'h66, 1'b0, 4'd0, 1'b0, "after_x13");

        // Randomized traffic over a narrow register window to force collisions.
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_flush = ($urandom_range(15) == 0);
            if ($urandom_range(2) == 0) set_alloc(AW'($urandom_range(15)), TAG_W'($urandom));
            for (int p = 0; p < NUM_WR; p++) begin
                if ($urandom_range(1) == 0) begin
                    ra = AW'($urandom_range(15));
                    set_wr(p, ra, $urandom, ($urandom_range(1) == 0) ? mt[ra] : TAG_W'($urandom));
                end
            end
            for (int q = 0; q < NUM_RD; q++) begin
                if ($urandom_range(3) == 0) ra = i_wr_rd[($urandom_range(NUM_WR-1))*AW +: AW];
                else ra = AW'($urandom_range(15));
                read_check(q, ra, $sformatf("rnd%0d.p%0d", cyc, q));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
